// File: rtl/trees_pkg.sv
// Shared definitions for the tree-ensemble inference core: node layout,
// FSM states and the float32 ordering used by the branch decision.
package trees_pkg;

    // Bit positions of the fields inside a 64-bit node word
    localparam int LEAF_BIT  = 0;
    localparam int FEAT_LSB  = 8;
    localparam int RIGHT_LSB = 16;
    localparam int VALUE_LSB = 32;

    // value is the float32 threshold (internal) or signed int32 (leaf)
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  rsvd;
        logic [7:0]  right_idx;
        logic [7:0]  feat_idx;
        logic [7:0]  flags;
    } node_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_FINISH
    } state_t;

    // Monotonic key: negatives get all bits flipped, positives get the sign flipped
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : {~x[31], x[30:0]};
    endfunction

    // Total order on float32 bit patterns; -0 sorts below +0, NaNs by bit pattern
    function automatic logic fp32_lt(input logic [31:0] a, input logic [31:0] b);
        return fp32_key(a) < fp32_key(b);
    endfunction

endpackage

// File: rtl/trees_node_mem.sv
// Node storage: one write port, one synchronous read port, no reset so it
// maps onto block RAM and keeps its contents across reset.
module trees_node_mem
    import trees_pkg::*;
#(
    parameter int DEPTH = 32768,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // Write and registered read; data appears one cycle after the address
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trees.sv
// Tree-ensemble inference core: walks every tree root-to-leaf against the
// stored feature vector and sums the leaf values into a signed 32-bit result.
module trees
    import trees_pkg::*;
#(
    parameter int N_TREES          = 128,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,      // active-high
    input  logic                                start,
    input  logic                                load_trees,
    input  logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
    input  logic [$clog2(N_TREES)-1:0]          n_tree,
    input  logic [63:0]                         tree_nodes,
    input  logic                                load_features,
    input  logic [31:0]                         n_feature,
    input  logic [63:0]                         features2,
    output logic signed [31:0]                  prediction,
    output logic                                done
);

    localparam int NW    = $clog2(N_NODE_AND_LEAFS);
    localparam int TW    = $clog2(N_TREES);
    localparam int AW    = TW + NW;
    localparam int SW    = NW + 1;
    localparam int FW    = $clog2(N_FEATURE);
    localparam int DEPTH = N_TREES * N_NODE_AND_LEAFS;

    state_t        r_state;
    logic [TW-1:0] r_tree;
    logic [NW-1:0] r_node;
    logic [SW-1:0] r_step;
    logic [31:0]   r_acc;
    logic [31:0]   r_pred;
    logic          r_done;
    logic [31:0]   r_feat [N_FEATURE];

    logic          w_idle;
    logic [63:0]   w_rdata;
    node_t         w_node;
    logic [31:0]   w_feat_val;
    logic          w_go_left;
    logic [NW-1:0] w_right;
    logic [SW-1:0] w_step_nx;
    logic          w_tree_end;
    logic          w_last_tree;
    logic [32:0]   w_hi_idx;
    logic          w_unused;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_node      = node_t'(w_rdata);
    assign w_right     = w_node.right_idx[NW-1:0];
    assign w_step_nx   = r_step + 1'b1;
    assign w_go_left   = fp32_lt(w_feat_val, w_node.value);
    assign w_last_tree = (r_tree == TW'(N_TREES - 1));
    // A tree ends at a leaf, or when the step budget runs out (loop guard)
    assign w_tree_end  = w_node.flags[LEAF_BIT] || (w_step_nx == SW'(N_NODE_AND_LEAFS));
    assign w_hi_idx    = {1'b0, n_feature} + 33'd1;
    assign w_unused    = ^{w_node.rsvd, w_node.flags, w_node.right_idx};

    trees_node_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (load_trees && w_idle),
        .i_waddr ({n_tree, n_node}),
        .i_wdata (tree_nodes),
        .i_re    (r_state == ST_READ),
        .i_raddr ({r_tree, r_node}),
        .o_rdata (w_rdata)
    );

    // Feature lookup; out-of-range indices read as +0.0
    always_comb begin
        w_feat_val = 32'h0;
        if ({24'h0, w_node.feat_idx} < 32'(N_FEATURE))
            w_feat_val = r_feat[w_node.feat_idx[FW-1:0]];
    end

    // Feature pair load in IDLE, dropping any half past the end of the vector
    always_ff @(posedge clk) begin
        if (w_idle && load_features) begin
            if (n_feature < 32'(N_FEATURE))
                r_feat[n_feature[FW-1:0]] <= features2[31:0];
            if (w_hi_idx < 33'(N_FEATURE))
                r_feat[w_hi_idx[FW-1:0]] <= features2[63:32];
        end
    end

    // Walk FSM: READ presents the address, EVAL consumes the node one cycle later
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
            r_tree  <= '0;
            r_node  <= '0;
            r_step  <= '0;
            r_acc   <= '0;
            r_pred  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_tree  <= '0;
                        r_node  <= '0;
                        r_step  <= '0;
                        r_done  <= 1'b0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: r_state <= ST_EVAL;
                ST_EVAL: begin
                    if (w_tree_end) begin
                        if (w_node.flags[LEAF_BIT]) r_acc <= r_acc + w_node.value;
                        if (w_last_tree) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_tree  <= r_tree + 1'b1;
                            r_node  <= '0;
                            r_step  <= '0;
                            r_state <= ST_READ;
                        end
                    end else begin
                        r_node  <= w_go_left ? r_node + 1'b1 : w_right;
                        r_step  <= w_step_nx;
                        r_state <= ST_READ;
                    end
                end
                ST_FINISH: begin
                    r_pred  <= r_acc;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prediction = r_pred;
    assign done       = r_done;

endmodule

// File: tb/tb_trees.sv
// Bench for trees: fixed vectors from the spec scenarios, hand-written busy /
// reset / loop sequences, and random forests against a recursive-walk model.
module tb_trees;
    import trees_pkg::*;

    localparam int NT = 4;
    localparam int NN = 256;
    localparam int NF = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               load_trees = 1'b0;
    logic [7:0]         n_node = '0;
    logic [1:0]         n_tree = '0;
    logic [63:0]        tree_nodes = '0;
    logic               load_features = 1'b0;
    logic [31:0]        n_feature = '0;
    logic [63:0]        features2 = '0;
    logic signed [31:0] prediction;
    logic               done;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] m_mem  [NT][NN];
    logic [31:0] m_feat [NF];

    always #5 clk = ~clk;

    trees #(
        .N_TREES          (NT),
        .N_NODE_AND_LEAFS (NN),
        .N_FEATURE        (NF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .load_trees    (load_trees),
        .n_node        (n_node),
        .n_tree        (n_tree),
        .tree_nodes    (tree_nodes),
        .load_features (load_features),
        .n_feature     (n_feature),
        .features2     (features2),
        .prediction    (prediction),
        .done          (done)
    );

    typedef struct {
        logic [63:0] n0;
        logic [31:0] f0;
        logic [31:0] pred;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] leaf(input logic [31:0] v);
        node_t n;
        n = '0;
        n.value = v;
        n.flags[LEAF_BIT] = 1'b1;
        return n;
    endfunction

    function automatic logic [63:0] inode(input int f, input int r, input logic [31:0] thr);
        node_t n;
        n = '0;
        n.value = thr;
        n.feat_idx = 8'(f);
        n.right_idx = 8'(r);
        return n;
    endfunction

    task automatic wr_node(input int t, input int n, input logic [63:0] w);
        load_trees = 1'b1;
        n_tree = 2'(t);
        n_node = 8'(n);
        tree_nodes = w;
        tick();
        load_trees = 1'b0;
        m_mem[t][n] = w;
    endtask

    task automatic wr_feat(input int idx, input logic [31:0] lo, input logic [31:0] hi);
        load_features = 1'b1;
        n_feature = 32'(idx);
        features2 = {hi, lo};
        tick();
        load_features = 1'b0;
        if (idx < NF) m_feat[idx] = lo;
        if (idx + 1 < NF) m_feat[idx + 1] = hi;
    endtask

    // Launch and count edges from the start edge until done
    task automatic run(output logic [31:0] pred, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_cleared_by_start", {31'h0, done}, 32'h0);
        lat = 0;
        while (!done && lat < 3000) begin
            tick();
            lat++;
        end
        chk("done_seen", {31'h0, done}, 32'h1);
        pred = prediction;
    endtask

    // Float order from sign and magnitude
    function automatic bit m_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    // Walk each tree; a tree giving up after NN internal steps adds nothing
    function automatic void model(output logic [31:0] sum, output int cyc);
        int          node;
        int          steps;
        int          fi;
        bit          fin;
        logic [63:0] w;
        logic [31:0] f;
        sum = 0;
        cyc = 1;
        for (int t = 0; t < NT; t++) begin
            node = 0;
            steps = 0;
            fin = 0;
            while (!fin) begin
                cyc += 2;
                w = m_mem[t][node];
                if (w[0]) begin
                    sum += w[63:32];
                    fin = 1;
                end else begin
                    fi = int'(w[15:8]);
                    f = (fi < NF) ? m_feat[fi] : 32'h0;
                    node = m_lt(f, w[63:32]) ? (node + 1) % NN : int'(w[23:16]);
                    steps++;
                    if (steps == NN) fin = 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h3F00_0000;
            5: return 32'h4000_0000;
            6: return 32'hC000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs [4];
        logic [31:0] p;
        logic [31:0] exp_p;
        int          lat;
        int          exp_lat;

        for (int t = 0; t < NT; t++)
            for (int n = 0; n < NN; n++) m_mem[t][n] = '0;
        for (int i = 0; i < NF; i++) m_feat[i] = '0;

        vecs[0] = '{64'h3F80_0000_0002_0000, 32'h3F00_0000, 32'h0000_0005, 11};
        vecs[1] = '{64'h3F80_0000_0002_0000, 32'h4000_0000, 32'hFFFF_FFFD, 11};
        vecs[2] = '{64'h3F80_0000_0002_0000, 32'h3F80_0000, 32'hFFFF_FFFD, 11};
        vecs[3] = '{64'h0000_0000_0002_0000, 32'h8000_0000, 32'h0000_0005, 11};

        // Reset state
        repeat (3) tick();
        chk("reset_prediction", prediction, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b0;
        tick();

        // Base forest
        wr_node(0, 1, 64'h0000_0005_0000_0001);
        wr_node(0, 2, 64'hFFFF_FFFD_0000_0001);
        for (int t = 1; t < NT; t++) wr_node(t, 0, 64'h0000_0000_0000_0001);

        foreach (vecs[i]) begin
            wr_node(0, 0, vecs[i].n0);
            wr_feat(0, vecs[i].f0, 32'h0);
            run(p, lat);
            chk($sformatf("vec%0d_prediction", i), p, vecs[i].pred);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Outputs hold while idle
        repeat (5) tick();
        chk("hold_done", {31'h0, done}, 32'h1);
        chk("hold_prediction", prediction, 32'h0000_0005);

        // Accumulator wrap
        for (int t = 0; t < NT; t++) wr_node(t, 0, leaf(32'h7FFF_FFFF));
        run(p, lat);
        chk("wrap_prediction", p, 32'hFFFF_FFFC);
        chk("wrap_latency", 32'(lat), 32'd9);

        // Pair write at 30/31
        wr_feat(30, 32'h3F00_0000, 32'h4000_0000);
        wr_node(0, 0, inode(30, 2, 32'h3F80_0000));
        wr_node(0, 1, leaf(32'd10));
        wr_node(0, 2, leaf(32'd20));
        wr_node(1, 0, inode(31, 2, 32'h3F80_0000));
        wr_node(1, 1, leaf(32'd100));
        wr_node(1, 2, leaf(32'd200));
        wr_node(2, 0, leaf(32'd0));
        wr_node(3, 0, leaf(32'd0));
        run(p, lat);
        chk("pair_prediction", p, 32'd210);
        chk("pair_latency", 32'(lat), 32'd13);

        // Feature index 40 reads +0.0, not feature 8
        wr_feat(8, 32'h4000_0000, 32'h4000_0000);
        wr_node(0, 0, inode(40, 2, 32'h0000_0001));
        wr_node(0, 1, leaf(32'd7));
        wr_node(0, 2, leaf(32'd9));
        run(p, lat);
        chk("feat40_prediction", p, 32'd207);

        // Node write and second start while busy are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        lat = 2;
        load_trees = 1'b1;
        n_tree = 2'd0;
        n_node = 8'd1;
        tree_nodes = leaf(32'd999);
        start = 1'b1;
        tick();
        lat++;
        load_trees = 1'b0;
        start = 1'b0;
        while (!done && lat < 3000) begin
            tick();
            lat++;
        end
        chk("busy_prediction", prediction, 32'd207);
        chk("busy_latency", 32'(lat), 32'd13);
        run(p, lat);
        chk("busy_mem_unchanged", p, 32'd207);

        // Self-loop gives up after NN steps and contributes 0
        wr_feat(0, 32'h4000_0000, 32'h0);
        wr_node(0, 0, inode(0, 0, 32'h3F80_0000));
        wr_node(1, 0, leaf(32'd1));
        wr_node(2, 0, leaf(32'd2));
        wr_node(3, 0, leaf(32'd3));
        run(p, lat);
        chk("loop_prediction", p, 32'd6);
        chk("loop_latency", 32'(lat), 32'd519);

        // Reset in the middle of the walk
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("midrst_prediction", prediction, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        run(p, lat);
        chk("postrst_prediction", p, 32'd6);
        chk("postrst_latency", 32'(lat), 32'd519);

        // Random forests against the model
        for (int it = 0; it < 12; it++) begin
            for (int t = 0; t < NT; t++) begin
                for (int n = 0; n < 16; n++) begin
                    if (n == 15 || ($urandom % 3) == 0)
                        wr_node(t, n, leaf($urandom));
                    else
                        wr_node(t, n, inode(int'($urandom % 36),
                                            int'($urandom_range(15, n + 1)), pick()));
                end
            end
            for (int i = 0; i < NF; i += 2) wr_feat(i, pick(), pick());
            model(exp_p, exp_lat);
            run(p, lat);
            chk($sformatf("rnd%0d_prediction", it), p, exp_p);
            chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'(exp_lat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
